// File: rtl/cu_multicycle.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer that latches one
// instruction per handshake and drives ALU, register-file, PC and memory strobes.
module cu_multicycle #(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned REG_W   = 2,
  parameter int unsigned ALU_MAX = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op,
  input  logic [REG_W-1:0]  rs2,
  input  logic [REG_W-1:0]  rd,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              mem_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [REG_W-1:0]  rout,
  output logic [REG_W-1:0]  rdest,
  output logic              write,
  output logic              pc_en,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned LOAD_OP  = ALU_MAX + 1;
  localparam int unsigned STORE_OP = ALU_MAX + 2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [OP_W-1:0]    ir_op_q, ir_op_d;
  logic [REG_W-1:0]   ir_rs2_q, ir_rs2_d;
  logic [REG_W-1:0]   ir_rd_q, ir_rd_d;

  logic is_nop, is_alu, is_load, is_store, is_halt;

  // Opcode class of the latched instruction
  always_comb begin
    is_nop   = (ir_op_q == '0);
    is_alu   = (ir_op_q != '0) && (ir_op_q <= OP_W'(ALU_MAX));
    is_load  = (ir_op_q == OP_W'(LOAD_OP));
    is_store = (ir_op_q == OP_W'(STORE_OP));
    is_halt  = (&ir_op_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      ir_op_q  <= '0;
      ir_rs2_q <= '0;
      ir_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      ir_op_q  <= ir_op_d;
      ir_rs2_q <= ir_rs2_d;
      ir_rd_q  <= ir_rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_op_d     = ir_op_q;
    ir_rs2_d    = ir_rs2_q;
    ir_rd_d     = ir_rd_q;
    instr_ready = 1'b0;
    alu_op      = '0;
    write       = 1'b0;
    pc_en       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        // Ready is masked while reset is held so every output reads 0 in reset
        instr_ready = rst;
        if (instr_valid) begin
          ir_op_d  = op;
          ir_rs2_d = rs2;
          ir_rd_d  = rd;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_alu) begin
          state_d = S_EXEC;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_en   = 1'b1;
          illegal = !is_nop;
        end
      end
      S_EXEC: begin
        alu_op  = ir_op_q;
        state_d = S_WB;
      end
      S_MEM: begin
        mem_rd = is_load;
        mem_wr = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            pc_en   = 1'b1;
          end
        end
      end
      S_WB: begin
        alu_op  = ir_op_q;
        write   = 1'b1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign rout  = ir_rs2_q;
  assign rdest = ir_rd_q;

endmodule

// File: doc/cu_multicycle.md
CU_MULTICYCLE -- requirements
Module: cu_multicycle

Interface
REQ-001 Parameter OP_W, default 4, opcode width in bits; legal range 4 to 8.
REQ-002 Parameter REG_W, default 2, register-address width in bits.
REQ-003 Parameter ALU_MAX, default 12, highest ALU opcode; legal range 1 to 2^OP_W-4.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-006 op  input  OP_W  opcode of presented instruction.
REQ-007 rs2  input  REG_W  second source register of presented instruction.
REQ-008 rd  input  REG_W  destination register of presented instruction.
REQ-009 instr_valid  input  1  instruction fields valid this cycle.
REQ-010 instr_ready  output  1  block accepts an instruction this cycle.
REQ-011 mem_ready  input  1  memory completes the pending access this cycle.
REQ-012 alu_op  output  OP_W  ALU operation select.
REQ-013 rout  output  REG_W  register-file read-port select, equal to latched rs2.
REQ-014 rdest  output  REG_W  register-file write address, equal to latched rd.
REQ-015 write  output  1  register-file write strobe.
REQ-016 pc_en  output  1  program-counter advance strobe.
REQ-017 mem_rd, mem_wr  output  1 each  memory read and write requests.
REQ-018 halted  output  1  core stopped by HALT.
REQ-019 illegal  output  1  one-cycle pulse flagging an undefined opcode.

Function
REQ-020 Opcode classes: 0 = NOP; 1 to ALU_MAX = ALU; ALU_MAX+1 = LOAD; ALU_MAX+2 = STORE; all-ones = HALT; all others = undefined.
REQ-021 Block implements an FSM with the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-022 In FETCH: instr_ready=1; on instr_valid=1, latch op/rs2/rd into an internal instruction register and go to DECODE; otherwise stay in FETCH.
REQ-023 instr_ready=0 in every state except FETCH; op/rs2/rd outside an accepted handshake have no effect.
REQ-024 In DECODE (one cycle): ALU goes to EXEC; LOAD or STORE goes to MEM; HALT goes to HALT; NOP or undefined goes to FETCH.
REQ-025 On the DECODE-to-FETCH transition for NOP or undefined opcodes, pc_en=1 for that one cycle.
REQ-026 On the DECODE-to-FETCH transition for an undefined opcode, illegal=1 for that one cycle.
REQ-027 In EXEC (one cycle): alu_op = latched op; next state is WB.
REQ-028 In MEM: mem_rd=1 (LOAD) or mem_wr=1 (STORE), held until mem_ready=1; on mem_ready, LOAD goes to WB and STORE goes to FETCH with pc_en=1 in the completing cycle.
REQ-029 In WB (one cycle): write=1, pc_en=1; next state is FETCH.
REQ-030 In HALT: halted=1; all strobes are 0; the state is left only by reset.
REQ-031 alu_op holds the latched op from EXEC through WB; it is 0 in every other state.
REQ-032 rout and rdest are valid from DECODE through WB/MEM and hold their last values in FETCH.
REQ-033 write, pc_en, mem_rd, mem_wr and illegal are mutually consistent: write and pc_en are never asserted except in the cases above; mem_rd and mem_wr are never asserted together.
REQ-034 ALU latency: handshake at cycle N, DECODE at N+1, EXEC at N+2, WB at N+3 with write=pc_en=1, instr_ready=1 again at N+4.
REQ-035 mem_ready is ignored outside MEM.
REQ-036 A MEM state whose mem_ready never arrives stalls indefinitely; there is no timeout.

Reset
REQ-037 While rst=0: state=FETCH; alu_op, rout and rdest = 0; write, pc_en, mem_rd, mem_wr, halted and illegal = 0; the instruction register is cleared.
REQ-038 Reset asserted mid-instruction (any state, including MEM with a request outstanding or HALT) abandons the instruction; mem_rd and mem_wr drop without waiting for mem_ready.
REQ-039 First handshake is accepted on the first rising edge after rst returns to 1.

Verification
REQ-040 ALU: op=4'b0011, rs2=2, rd=1, one-cycle valid -> alu_op=3 at N+2 and N+3; write=pc_en=1 only at N+3; rout=2, rdest=1.
REQ-041 LOAD: op=13, mem_ready held low for 3 cycles then high -> mem_rd=1 for 4 cycles, then one WB cycle with write=1, then FETCH.
REQ-042 STORE: op=14, mem_ready high on the first MEM cycle -> mem_wr=1 and pc_en=1 in the same cycle, write never asserted.
REQ-043 HALT: op=15 -> halted=1 from N+2; further instr_valid pulses are ignored; rst=0 clears halted asynchronously.
REQ-044 Undefined opcode (OP_W=5, op=5'd20) -> illegal=1 and pc_en=1 at N+1, back to FETCH at N+2.
REQ-045 Reset mid-MEM: rst=0 while mem_rd=1 -> all outputs 0 without waiting for a clock edge; after release, instr_ready=1.
